// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the I-cache and D-cache.
// The owner holds the port until its request drops and all of its reads have returned.
module mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_imem_addr,
  input  logic        i_imem_ren,
  output logic        o_imem_ready,
  output logic [31:0] o_imem_rdata,
  output logic        o_imem_valid,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_grant_i,
  output logic        o_grant_d,
  output logic        o_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_d;
  logic          err;

  logic own_i, own_d;
  logic i_req, d_req;
  logic own_ren, own_wen;
  logic room, rd_acc, resp, rel;

  always_comb begin
    own_i   = (state == GNT_I);
    own_d   = (state == GNT_D);
    i_req   = i_imem_ren;
    d_req   = i_dmem_ren | i_dmem_wen;
    own_ren = (own_i & i_imem_ren) | (own_d & i_dmem_ren);
    own_wen = own_d & i_dmem_wen;
    room    = (cnt < CW'(MAX_OUTSTANDING));
    rd_acc  = own_ren & i_mem_ready & room;
    // A response with nothing outstanding is dropped rather than routed.
    resp    = i_mem_valid & (cnt != '0);
  end

  always_comb begin
    o_imem_ready = own_i & i_mem_ready & room;
    o_dmem_ready = own_d & i_mem_ready & room;
    o_imem_valid = own_i & resp;
    o_dmem_valid = own_d & resp;
    o_imem_rdata = i_mem_rdata;
    o_dmem_rdata = i_mem_rdata;
    o_mem_ren    = own_ren & room;
    o_mem_wen    = own_wen & room;
    o_mem_addr   = own_i ? i_imem_addr : (own_d ? i_dmem_addr : '0);
    o_mem_wdata  = own_d ? i_dmem_wdata : '0;
    o_mem_mask   = own_i ? '1 : (own_d ? i_dmem_mask : '0);
    o_grant_i    = own_i;
    o_grant_d    = own_d;
    o_err        = err;
  end

  always_comb begin
    cnt_nxt = cnt;
    case ({rd_acc, resp})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    rel       = (own_i | own_d) & ~(own_ren | own_wen) & (cnt_nxt == '0);
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = last_d ? GNT_I : GNT_D;
        else if (d_req)     state_nxt = GNT_D;
        else if (i_req)     state_nxt = GNT_I;
      end
      GNT_I:   if (rel) state_nxt = d_req ? GNT_D : IDLE;
      GNT_D:   if (rel) state_nxt = i_req ? GNT_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rel) last_d <= own_d;
      if (i_mem_valid && (cnt == '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus a read-data scoreboard,
// followed by a hand-written handover sequence.
module tb_mem_arbiter;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic        imem_ren, dmem_ren, dmem_wen, mem_ready, mem_valid;
  logic [3:0]  dmem_mask;
  logic        imem_ready, imem_valid, dmem_ready, dmem_valid;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        mem_ren, mem_wen, grant_i, grant_d, err;
  logic [3:0]  mem_mask;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_imem_addr(imem_addr), .i_imem_ren(imem_ren), .o_imem_ready(imem_ready),
    .o_imem_rdata(imem_rdata), .o_imem_valid(imem_valid),
    .i_dmem_addr(dmem_addr), .i_dmem_ren(dmem_ren), .i_dmem_wen(dmem_wen),
    .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask), .o_dmem_ready(dmem_ready),
    .o_dmem_rdata(dmem_rdata), .o_dmem_valid(dmem_valid),
    .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid),
    .o_grant_i(grant_i), .o_grant_d(grant_d), .o_err(err)
  );

  typedef struct {
    logic        rst_n, iren, dren, dwen, mrdy, mval;
    logic [8:0]  exp;   // {gnt_i, gnt_d, i_rdy, d_rdy, i_vld, d_vld, m_ren, m_wen, err}
    logic [31:0] eaddr;
  } vec_t;

  vec_t        vt[$];
  logic [32:0] sb[$];   // {to_i_side, rdata}
  int          checks = 0;
  int          errors = 0;

  task automatic add(input logic r, input logic i, input logic d, input logic w,
                     input logic rd, input logic v, input logic [8:0] e, input logic [31:0] a);
    vec_t x;
    x.rst_n = r; x.iren = i; x.dren = d; x.dwen = w; x.mrdy = rd; x.mval = v;
    x.exp = e; x.eaddr = a;
    vt.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic sb_pop();
    logic [32:0] e;
    if (imem_valid || dmem_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got valid i=%b d=%b want none", imem_valid, dmem_valid);
      end else begin
        e = sb.pop_front();
        if ({imem_valid, imem_rdata} !== e || dmem_rdata !== e[31:0]) begin
          errors++;
          $display("FAIL sb_data got %b/%h want %b/%h", imem_valid, imem_rdata, e[32], e[31:0]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] act;
    int n;
    rst_n = 1'b0; imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    imem_addr = 32'h100; dmem_addr = 32'h200;
    dmem_wdata = 32'hDEADBEEF; dmem_mask = 4'b0011;

    // I-only read, response two cycles after accept
    add(1,1,0,0,1,0, 9'b00_00_00_00_0, 32'h0);
    add(1,1,0,0,1,0, 9'b10_10_00_10_0, 32'h100);
    add(1,0,0,0,1,0, 9'b10_10_00_00_0, 32'h100);
    add(1,0,0,0,1,1, 9'b10_10_10_00_0, 32'h100);
    add(1,0,0,0,0,0, 9'b00_00_00_00_0, 32'h0);
    // simultaneous I and D from reset: D first, then I without an idle cycle
    add(0,0,0,0,0,0, 9'b00_00_00_00_0, 32'h0);
    add(1,1,1,0,1,0, 9'b00_00_00_00_0, 32'h0);
    add(1,1,1,0,1,0, 9'b01_01_00_10_0, 32'h200);
    add(1,1,0,0,1,1, 9'b01_01_01_00_0, 32'h200);
    add(1,1,0,0,1,0, 9'b10_10_00_10_0, 32'h100);
    add(1,0,0,0,1,1, 9'b10_10_10_00_0, 32'h100);
    add(1,0,0,0,0,0, 9'b00_00_00_00_0, 32'h0);
    // D write
    add(1,0,0,1,1,0, 9'b00_00_00_00_0, 32'h0);
    add(1,0,0,1,1,0, 9'b01_01_00_01_0, 32'h200);
    add(1,0,0,0,1,0, 9'b01_01_00_00_0, 32'h200);
    add(1,0,0,0,1,0, 9'b00_00_00_00_0, 32'h0);
    // three I reads against a limit of two outstanding
    add(1,1,0,0,1,0, 9'b00_00_00_00_0, 32'h0);
    add(1,1,0,0,1,0, 9'b10_10_00_10_0, 32'h100);
    add(1,1,0,0,1,0, 9'b10_10_00_10_0, 32'h100);
    add(1,1,0,0,1,0, 9'b10_00_00_00_0, 32'h100);
    add(1,1,0,0,1,0, 9'b10_00_00_00_0, 32'h100);
    add(1,1,0,0,1,1, 9'b10_00_10_00_0, 32'h100);
    add(1,1,0,0,1,1, 9'b10_10_10_10_0, 32'h100);
    add(1,0,0,0,1,1, 9'b10_10_10_00_0, 32'h100);
    add(1,0,0,0,1,0, 9'b00_00_00_00_0, 32'h0);
    // stray valid in IDLE sets sticky error; reset clears it
    add(1,0,0,0,0,1, 9'b00_00_00_00_0, 32'h0);
    add(1,0,0,0,0,0, 9'b00_00_00_00_1, 32'h0);
    add(1,0,0,0,0,0, 9'b00_00_00_00_1, 32'h0);
    add(0,0,0,0,0,0, 9'b00_00_00_00_1, 32'h0);
    add(1,0,0,0,0,0, 9'b00_00_00_00_0, 32'h0);
    // reset during GNT_D with two reads outstanding
    add(1,0,1,0,1,0, 9'b00_00_00_00_0, 32'h0);
    add(1,0,1,0,1,0, 9'b01_01_00_10_0, 32'h200);
    add(1,0,1,0,1,0, 9'b01_01_00_10_0, 32'h200);
    add(0,0,1,0,1,0, 9'b01_00_00_00_0, 32'h200);
    add(1,0,0,0,1,1, 9'b00_00_00_00_0, 32'h0);
    add(1,0,0,0,0,0, 9'b00_00_00_00_1, 32'h0);
    add(0,0,0,0,0,0, 9'b00_00_00_00_1, 32'h0);
    add(1,0,0,0,0,0, 9'b00_00_00_00_0, 32'h0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      rst_n = vt[i].rst_n; imem_ren = vt[i].iren; dmem_ren = vt[i].dren;
      dmem_wen = vt[i].dwen; mem_ready = vt[i].mrdy; mem_valid = vt[i].mval;
      mem_rdata = 32'hC0DE_0000 + 32'(i);
      if (vt[i].exp[4] || vt[i].exp[3]) sb.push_back({vt[i].exp[4], mem_rdata});
      @(negedge clk);
      act = {grant_i, grant_d, imem_ready, dmem_ready, imem_valid, dmem_valid,
             mem_ren, mem_wen, err};
      check($sformatf("vec%0d_ctl", i), {23'd0, act}, {23'd0, vt[i].exp});
      check($sformatf("vec%0d_addr", i), mem_addr, vt[i].eaddr);
      check($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].exp[7] ? 32'hDEADBEEF : 32'h0);
      check($sformatf("vec%0d_mask", i), {28'd0, mem_mask},
            vt[i].exp[8] ? 32'hF : (vt[i].exp[7] ? 32'h3 : 32'h0));
      sb_pop();
    end

    // D streams three writes while I waits, then I takes over with no idle cycle
    @(posedge clk); #1;
    imem_ren = 1'b1; dmem_ren = 1'b0; dmem_wen = 1'b1; mem_ready = 1'b1; mem_valid = 1'b0;
    n = 0;
    while (!grant_d && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    check("arb_latency", n, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("burst%0d", k), {29'd0, grant_d, grant_i, mem_wen}, 32'b101);
      @(posedge clk); #1;
    end
    dmem_wen = 1'b0;
    @(negedge clk);
    check("d_release", {29'd0, grant_d, grant_i, mem_wen}, 32'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("handover", {29'd0, grant_d, grant_i, mem_ren}, 32'b011);
    @(posedge clk); #1;
    imem_ren = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
    sb.push_back({1'b1, mem_rdata});
    @(negedge clk);
    check("h_valid", {30'd0, imem_valid, dmem_valid}, 32'b10);
    sb_pop();
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("h_idle", {29'd0, grant_i, grant_d, err}, 32'b000);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
